// File: rtl/move_distance_ctrl.sv
// Runs one "move N encoder edges" command for a single wheel. It clears pos1,
// drives the motor until the target is reached, brakes, and then debits the target from pos2.
module move_distance_ctrl #(
    parameter int unsigned DEADTIME_CYCLES = 100,
    parameter int unsigned BRAKE_CYCLES    = 1000,
    parameter int unsigned STALL_CYCLES    = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_distance,
    input  logic        cmd_dir,
    input  logic        abort,
    input  logic [31:0] pos1,
    output logic        counter_clear,
    output logic        counter_subtract,
    output logic [31:0] counter_distance,
    output logic        motor_en,
    output logic        motor_dir,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [31:0] overshoot
);

    localparam int DW = $clog2(DEADTIME_CYCLES + 1);
    localparam int BW = $clog2(BRAKE_CYCLES + 1);
    localparam int SW = $clog2(STALL_CYCLES + 1);

    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEADTIME_CYCLES - 1);
    localparam logic [BW-1:0] BRAKE_LAST = BW'(BRAKE_CYCLES - 1);
    localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_CYCLES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_DEAD  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_BRAKE = 3'd4;
    localparam logic [2:0] S_SUB   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ABORTED = 2'b01;
    localparam logic [1:0] ST_STALL   = 2'b10;

    logic [2:0]    state_q, state_d;
    logic [31:0]   target_q, target_d;
    logic          dir_q, dir_d;
    // motor_dir doubles as the remembered last direction; both only change on DEAD entry.
    logic          motor_dir_q, motor_dir_d;
    logic [DW-1:0] dead_cnt_q, dead_cnt_d;
    logic [BW-1:0] brake_cnt_q, brake_cnt_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic [31:0]   pos1_prev_q, pos1_prev_d;
    logic [1:0]    pend_status_q, pend_status_d;
    logic [31:0]   pend_over_q, pend_over_d;
    logic [1:0]    status_q, status_d;
    logic [31:0]   overshoot_q, overshoot_d;

    logic [SW-1:0] stall_eff;

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        dir_d         = dir_q;
        motor_dir_d   = motor_dir_q;
        dead_cnt_d    = dead_cnt_q;
        brake_cnt_d   = brake_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        pos1_prev_d   = pos1;
        pend_status_d = pend_status_q;
        pend_over_d   = pend_over_q;
        status_d      = status_q;
        overshoot_d   = overshoot_q;
        // Quiet-cycle count seen this cycle: any pos1 movement restarts it.
        stall_eff     = (pos1 != pos1_prev_q) ? '0 : stall_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    target_d = cmd_distance;
                    dir_d    = cmd_dir;
                    if (cmd_distance == 32'd0) begin
                        state_d     = S_DONE;
                        status_d    = ST_OK;
                        overshoot_d = 32'd0;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (dir_q != motor_dir_q) begin
                    state_d     = S_DEAD;
                    motor_dir_d = dir_q;
                    dead_cnt_d  = '0;
                end else begin
                    state_d     = S_RUN;
                    stall_cnt_d = '0;
                end
            end
            S_DEAD: begin
                if (abort) begin
                    state_d       = S_BRAKE;
                    pend_status_d = ST_ABORTED;
                    brake_cnt_d   = '0;
                end else if (dead_cnt_q == DEAD_LAST) begin
                    state_d     = S_RUN;
                    stall_cnt_d = '0;
                end else begin
                    dead_cnt_d = dead_cnt_q + DW'(1);
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d       = S_BRAKE;
                    pend_status_d = ST_ABORTED;
                    brake_cnt_d   = '0;
                end else if (pos1 >= target_q) begin
                    state_d       = S_BRAKE;
                    pend_status_d = ST_OK;
                    brake_cnt_d   = '0;
                end else if (stall_eff == STALL_MAX) begin
                    state_d       = S_BRAKE;
                    pend_status_d = ST_STALL;
                    brake_cnt_d   = '0;
                    stall_cnt_d   = STALL_MAX;
                end else begin
                    stall_cnt_d = stall_eff + SW'(1);
                end
            end
            S_BRAKE: begin
                if (brake_cnt_q == BRAKE_LAST) begin
                    state_d     = S_SUB;
                    pend_over_d = (pos1 > target_q) ? (pos1 - target_q) : 32'd0;
                end else begin
                    brake_cnt_d = brake_cnt_q + BW'(1);
                end
            end
            S_SUB: begin
                // Result is published only when done pulses so it stays stable between completions.
                state_d     = S_DONE;
                status_d    = pend_status_q;
                overshoot_d = pend_over_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            target_q      <= 32'd0;
            dir_q         <= 1'b0;
            motor_dir_q   <= 1'b0;
            dead_cnt_q    <= '0;
            brake_cnt_q   <= '0;
            stall_cnt_q   <= '0;
            pos1_prev_q   <= 32'd0;
            pend_status_q <= ST_OK;
            pend_over_q   <= 32'd0;
            status_q      <= ST_OK;
            overshoot_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            dir_q         <= dir_d;
            motor_dir_q   <= motor_dir_d;
            dead_cnt_q    <= dead_cnt_d;
            brake_cnt_q   <= brake_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            pos1_prev_q   <= pos1_prev_d;
            pend_status_q <= pend_status_d;
            pend_over_q   <= pend_over_d;
            status_q      <= status_d;
            overshoot_q   <= overshoot_d;
        end
    end

    assign cmd_ready        = (state_q == S_IDLE);
    assign busy             = ~cmd_ready;
    assign counter_clear    = (state_q == S_CLEAR);
    assign counter_subtract = (state_q == S_SUB);
    assign counter_distance = target_q;
    assign motor_en         = (state_q == S_RUN);
    assign motor_dir        = motor_dir_q;
    assign done             = (state_q == S_DONE);
    assign status           = status_q;
    assign overshoot        = overshoot_q;

endmodule

// File: tb/tb_move_distance_ctrl.sv
// Bench for move_distance_ctrl: a small position-counter model, a per-cycle
// timeline model of each move, and directed command scenarios.
module tb_move_distance_ctrl;

    localparam int D = 4;
    localparam int B = 6;
    localparam int S = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_distance = 32'd0;
    logic        cmd_dir = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] pos1 = 32'd0;
    logic        counter_clear;
    logic        counter_subtract;
    logic [31:0] counter_distance;
    logic        motor_en;
    logic        motor_dir;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [31:0] overshoot;

    logic        edge_in = 1'b0;
    logic [31:0] pos2 = 32'd0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    move_distance_ctrl #(
        .DEADTIME_CYCLES(D),
        .BRAKE_CYCLES   (B),
        .STALL_CYCLES   (S)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_distance    (cmd_distance),
        .cmd_dir         (cmd_dir),
        .abort           (abort),
        .pos1            (pos1),
        .counter_clear   (counter_clear),
        .counter_subtract(counter_subtract),
        .counter_distance(counter_distance),
        .motor_en        (motor_en),
        .motor_dir       (motor_dir),
        .busy            (busy),
        .done            (done),
        .status          (status),
        .overshoot       (overshoot)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Position counter: clear lands one cycle after counter_clear; pos2 is the odometer.
    always @(posedge clk) begin
        if (counter_clear === 1'b1) pos1 <= 32'd0;
        else if (edge_in) pos1 <= pos1 + 32'd1;
        pos2 <= pos2 + (edge_in ? 32'd1 : 32'd0)
                     - ((counter_subtract === 1'b1) ? counter_distance : 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Move timeline model: accept cycle a, run start, end-of-drive cycle e, then B brake cycles, SUB, DONE.
    bit          m_active = 0, m_zero = 0, m_e_known = 0, m_dirchg = 0;
    int          m_a = 0, m_run = 0, m_e = 0, m_lastchg = 0;
    logic [31:0] m_tgt = 0, m_dist = 0, m_over = 0, m_pend_over = 0, m_prev_pos = 0;
    logic [1:0]  m_status = 0, m_pend_status = 0;
    logic        m_dir = 0, m_mdir = 0;

    always @(negedge clk) begin
        logic        e_en, e_clr, e_sub, e_done, e_mdir;
        logic [1:0]  e_st;
        logic [31:0] e_ov;
        int          n, quiet_from;
        n = cyc;
        if (reset) begin
            m_active = 0; m_status = 0; m_over = 0; m_dist = 0; m_mdir = 0;
        end else begin
            e_clr  = m_active && !m_zero && n == m_a + 1;
            e_en   = m_active && !m_zero && n >= m_run && (!m_e_known || n <= m_e);
            e_sub  = m_active && m_e_known && n == m_e + B + 1;
            e_done = m_active && ((m_zero && n == m_a + 1) || (m_e_known && n == m_e + B + 2));
            e_st   = e_done ? m_pend_status : m_status;
            e_ov   = e_done ? m_pend_over : m_over;
            e_mdir = (m_active && !m_zero && m_dirchg && n >= m_a + 2) ? m_dir : m_mdir;
            chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !m_active});
            chk("busy", {31'd0, busy}, {31'd0, m_active});
            chk("counter_clear", {31'd0, counter_clear}, {31'd0, e_clr});
            chk("motor_en", {31'd0, motor_en}, {31'd0, e_en});
            chk("counter_subtract", {31'd0, counter_subtract}, {31'd0, e_sub});
            chk("done", {31'd0, done}, {31'd0, e_done});
            chk("status", {30'd0, status}, {30'd0, e_st});
            chk("overshoot", overshoot, e_ov);
            chk("motor_dir", {31'd0, motor_dir}, {31'd0, e_mdir});
            chk("counter_distance", counter_distance, m_dist);
            if (m_active) begin
                if (pos1 != m_prev_pos) m_lastchg = n;
                if (!m_zero && !m_e_known && n >= m_a + 2) begin
                    quiet_from = (m_lastchg > m_run) ? m_lastchg : m_run;
                    if (abort) begin
                        m_e_known = 1; m_e = n; m_pend_status = 2'b01;
                    end else if (n >= m_run && pos1 >= m_tgt) begin
                        m_e_known = 1; m_e = n; m_pend_status = 2'b00;
                    end else if (n >= m_run && n - quiet_from == S) begin
                        m_e_known = 1; m_e = n; m_pend_status = 2'b10;
                    end
                end
                if (m_e_known && n == m_e + B)
                    m_pend_over = (pos1 > m_tgt) ? pos1 - m_tgt : 32'd0;
                if (e_done) begin
                    m_active = 0; m_status = e_st; m_over = e_ov; m_mdir = e_mdir;
                    $display("txn done cyc=%0d dist=%0d status=%0d overshoot=%0d", n, m_tgt, e_st, e_ov);
                end
            end else if (cmd_valid) begin
                m_active = 1; m_a = n; m_tgt = cmd_distance; m_dist = cmd_distance;
                m_dir = cmd_dir; m_zero = (cmd_distance == 32'd0); m_e_known = 0;
                m_dirchg = (cmd_dir != m_mdir);
                m_run = n + 2 + (m_dirchg ? D : 0);
                m_pend_status = 2'b00; m_pend_over = 32'd0;
                $display("txn accept cyc=%0d dist=%0d dir=%0d", n, cmd_distance, cmd_dir);
            end
        end
        m_prev_pos = pos1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 motor_en, 1 done, 2 cmd_ready; returns the cycle index where it was seen.
    task automatic wait_sig(input int which, input string name, output int at);
        bit hit;
        hit = 0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clk);
            case (which)
                0: hit = motor_en;
                1: hit = done;
                default: hit = cmd_ready;
            endcase
        end
        at = cyc;
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL timeout_%s cyc=%0d actual=not_seen expected=seen", name, cyc);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic dr, output int acc);
        tick();
        cmd_valid = 1'b1; cmd_distance = d; cmd_dir = dr;
        wait_sig(2, "ready", acc);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic edges(input int k);
        for (int i = 0; i < k; i++) begin
            edge_in = 1'b1;
            tick();
        end
        edge_in = 1'b0;
    endtask

    initial begin
        int a, r, dn, seen_done;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_motor_en", {31'd0, motor_en}, 32'd0);
        chk("rst_status", {30'd0, status}, 32'd0);

        // 1: move 5 forward, direction change inserts deadtime
        send(32'd5, 1'b1, a);
        wait_sig(0, "t1_motor", r);
        chk("t1_run_start", r - a, 32'd6);
        tick();
        edges(5);
        wait_sig(1, "t1_done", dn);
        chk("t1_done_lat", dn - a, 32'd20);
        chk("t1_status", {30'd0, status}, 32'd0);
        chk("t1_overshoot", overshoot, 32'd0);
        chk("t1_pos2", pos2, 32'd0);

        // 2: same direction, 2 edges arrive during brake
        send(32'd3, 1'b1, a);
        wait_sig(0, "t2_motor", r);
        chk("t2_run_start", r - a, 32'd2);
        tick();
        edges(3);
        edges(2);
        wait_sig(1, "t2_done", dn);
        chk("t2_done_lat", dn - a, 32'd14);
        chk("t2_overshoot", overshoot, 32'd2);
        chk("t2_pos2", pos2, 32'd2);

        // 3: abort after 4 edges, full target still debited
        send(32'd10, 1'b1, a);
        wait_sig(0, "t3_motor", r);
        tick();
        edges(4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_sig(1, "t3_done", dn);
        chk("t3_status", {30'd0, status}, 32'd1);
        chk("t3_pos2", pos2, 32'hFFFF_FFFC);

        // 4: two edges then silence -> stall 50 cycles after the last edge
        send(32'd10, 1'b1, a);
        wait_sig(0, "t4_motor", r);
        tick();
        edges(2);
        wait_sig(1, "t4_done", dn);
        chk("t4_done_after_run", dn - r, 32'd61);
        chk("t4_status", {30'd0, status}, 32'd2);
        chk("t4_overshoot", overshoot, 32'd0);
        chk("t4_pos2", pos2, 32'hFFFF_FFF4);

        // 6: reset in the middle of RUN
        send(32'd10, 1'b0, a);
        wait_sig(0, "t6_motor", r);
        chk("t6_run_start", r - a, 32'd6);
        tick();
        edges(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_motor_en", {31'd0, motor_en}, 32'd0);
        chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t6_status", {30'd0, status}, 32'd0);
        chk("t6_motor_dir", {31'd0, motor_dir}, 32'd0);
        seen_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("t6_no_done", seen_done, 32'd0);

        // 5: zero distance, then a move with cmd_valid pulsed while busy
        send(32'd0, 1'b1, a);
        wait_sig(1, "t5_zero_done", dn);
        chk("t5_zero_lat", dn - a, 32'd1);
        send(32'd3, 1'b1, a);
        tick();
        cmd_valid = 1'b1; cmd_distance = 32'd99; cmd_dir = 1'b0;
        repeat (3) tick();
        cmd_valid = 1'b0;
        wait_sig(0, "t5_motor", r);
        tick();
        edges(3);
        wait_sig(1, "t5_done", dn);
        chk("t5_distance", counter_distance, 32'd3);
        chk("t5_status", {30'd0, status}, 32'd0);
        chk("t5_pos2", pos2, 32'hFFFF_FFF6);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
